// File: rtl/act_quant_unit.sv
// Multi-lane activation post-processing: rounding requant shift, selectable activation,
// saturation, per-beat zero mask and a saturating zero counter, as a 2-stage valid/ready pipe.
module act_quant_unit #(
  parameter int DATA_W_IN  = 24,
  parameter int DATA_W_OUT = 8,
  parameter int LANES      = 4,
  parameter int SH_W       = 5,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES*DATA_W_IN-1:0]    in_data,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    cfg_mode,
  input  logic [SH_W-1:0]               cfg_shift,
  input  logic [DATA_W_OUT-1:0]         cfg_clip,
  input  logic [SH_W-1:0]               cfg_leak_sh,
  output logic [LANES*DATA_W_OUT-1:0]   out_data,
  output logic [LANES-1:0]              out_zero_mask,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              zero_cnt
);

  localparam int RW = DATA_W_IN + 1;
  localparam int PW = $clog2(LANES + 1);

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_W_OUT+1){1'b0}}, {(DATA_W_OUT-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_W_OUT+1){1'b1}}, {(DATA_W_OUT-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_LEAKY  = 2'd3
  } mode_e;

  // Round-half-up shift: (x + 2^(s-1)) >> s equals (x >> s) plus bit s-1 of x, which
  // stays exact for any shift amount without widening the adder.
  function automatic logic signed [RW-1:0] requant(input logic signed [DATA_W_IN-1:0] x,
                                                   input logic [SH_W-1:0] sh);
    logic signed [RW-1:0] xe;
    logic signed [RW-1:0] sv;
    logic                 rb;
    xe = {x[DATA_W_IN-1], x};
    sv = xe >>> sh;
    if (sh == '0)                      rb = 1'b0;
    else if (sh > SH_W'(DATA_W_IN))    rb = xe[RW-1];
    else                               rb = xe[sh - 1'b1];
    return sv + $signed({{(RW-1){1'b0}}, rb});
  endfunction

  function automatic logic [DATA_W_OUT-1:0] activate(input logic signed [RW-1:0] r,
                                                     input mode_e mode,
                                                     input logic signed [DATA_W_OUT-1:0] clip,
                                                     input logic [SH_W-1:0] leak_sh);
    logic signed [RW-1:0] clip_e;
    logic signed [RW-1:0] a;
    logic [DATA_W_OUT-1:0] res;
    clip_e = {{(RW-DATA_W_OUT){clip[DATA_W_OUT-1]}}, clip};
    case (mode)
      MODE_RELU:  a = r[RW-1] ? '0 : r;
      MODE_CLIP: begin
        if (clip[DATA_W_OUT-1] || r[RW-1]) a = '0;
        else if (r > clip_e)               a = clip_e;
        else                               a = r;
      end
      MODE_LEAKY: a = r[RW-1] ? (r >>> leak_sh) : r;
      default:    a = r;
    endcase
    if (a > SAT_MAX)      res = SAT_MAX[DATA_W_OUT-1:0];
    else if (a < SAT_MIN) res = SAT_MIN[DATA_W_OUT-1:0];
    else                  res = a[DATA_W_OUT-1:0];
    return res;
  endfunction

  logic                  s1_valid;
  logic                  s1_last;
  mode_e                 s1_mode;
  logic [DATA_W_OUT-1:0] s1_clip;
  logic [SH_W-1:0]       s1_leak_sh;
  logic signed [RW-1:0]  s1_r [LANES];
  logic signed [RW-1:0]  rnd  [LANES];

  logic                        s2_ready;
  logic [LANES*DATA_W_OUT-1:0] nxt_data;
  logic [LANES-1:0]            nxt_mask;
  logic [PW-1:0]               zero_pop;
  logic [CNT_W:0]              cnt_sum;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  always_comb begin
    for (int i = 0; i < LANES; i++)
      rnd[i] = requant(in_data[i*DATA_W_IN +: DATA_W_IN], cfg_shift);
  end

  // NOTE: every variable in an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    nxt_data = '0;
    nxt_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      nxt_data[i*DATA_W_OUT +: DATA_W_OUT] = activate(s1_r[i], s1_mode, s1_clip, s1_leak_sh);
      nxt_mask[i] = (nxt_data[i*DATA_W_OUT +: DATA_W_OUT] == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the small lane datapath registers are reset too, giving deterministic outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mode    <= MODE_BYPASS;
      s1_clip    <= '0;
      s1_leak_sh <= '0;
      for (int i = 0; i < LANES; i++) s1_r[i] <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last    <= in_last;
        s1_mode    <= mode_e'(cfg_mode);
        s1_clip    <= cfg_clip;
        s1_leak_sh <= cfg_leak_sh;
        for (int i = 0; i < LANES; i++) s1_r[i] <= rnd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_zero_mask <= '0;
      out_last      <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data      <= nxt_data;
        out_zero_mask <= nxt_mask;
        out_last      <= s1_last;
      end
    end
  end

  always_comb begin
    zero_pop = '0;
    for (int i = 0; i < LANES; i++) zero_pop = zero_pop + PW'(out_zero_mask[i]);
  end

  assign cnt_sum = {1'b0, zero_cnt} + (CNT_W+1)'(zero_pop);

  // Clear wins over a same-cycle increment; the carry out of cnt_sum signals saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      zero_cnt <= '0;
    else if (cnt_clr)                zero_cnt <= '0;
    else if (out_valid && out_ready) zero_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

endmodule
